// File: rtl/calc_pkg.sv
// Shared definitions for the calculator: entry stage encoding and ALU opcodes.
package calc_pkg;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_OP   = 2'd2,
    S_SHOW = 2'd3
  } stage_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_NEG = 2'b11;

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes and debounces one raw pushbutton, emitting a one-cycle pulse per accepted press.
module button_debouncer
  import calc_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CntW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic [1:0]      r_fill;
  logic            r_armed;
  logic            r_stable;
  logic            r_stable_q;
  logic            r_press;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;
  logic            w_stable_d;

  always_comb begin
    w_cnt_d    = r_cnt;
    w_stable_d = r_stable;
    if (r_sync2 == r_stable) begin
      w_cnt_d = '0;
    end else if (r_cnt == CntMax) begin
      w_stable_d = r_sync2;
      w_cnt_d    = '0;
    end else begin
      w_cnt_d = r_cnt + CntW'(1);
    end
  end

  // r_armed blocks the pulse for a button already held at reset release: it is only set once
  // the synchronizer has refilled after reset and shows the button released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_fill     <= 2'b00;
      r_armed    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_q <= 1'b0;
      r_press    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= btn_raw;
      r_sync2    <= r_sync1;
      r_fill     <= {r_fill[0], 1'b1};
      if (r_fill[1] && !r_sync2) r_armed <= 1'b1;
      r_stable   <= w_stable_d;
      r_stable_q <= r_stable;
      r_press    <= r_stable & ~r_stable_q & r_armed;
      r_cnt      <= w_cnt_d;
    end
  end

  assign press = r_press;

endmodule

// File: rtl/calc_operand_entry.sv
// Operand/opcode entry FSM: latches i1, i2 and ctrl from the switches on successive ENTER presses.
module calc_operand_entry
  import calc_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       btn_enter,
  input  logic       btn_clear,
  output logic [3:0] i1,
  output logic [3:0] i2,
  output logic [1:0] ctrl,
  output logic       valid,
  output logic [1:0] stage
);

  logic       w_enter;
  logic       w_clear;
  stage_e     r_stage;
  stage_e     w_stage_d;
  logic [3:0] r_i1;
  logic [3:0] w_i1_d;
  logic [3:0] r_i2;
  logic [3:0] w_i2_d;
  logic [1:0] r_ctrl;
  logic [1:0] w_ctrl_d;
  logic       r_valid;
  logic       w_valid_d;

  button_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_enter_deb (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_enter),
    .press   (w_enter)
  );

  button_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_clear_deb (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_clear),
    .press   (w_clear)
  );

  always_comb begin
    w_stage_d = r_stage;
    w_i1_d    = r_i1;
    w_i2_d    = r_i2;
    w_ctrl_d  = r_ctrl;
    w_valid_d = r_valid;
    // CLEAR outranks a coincident ENTER, which is simply dropped.
    if (w_clear) begin
      w_stage_d = S_A;
      w_i1_d    = 4'h0;
      w_i2_d    = 4'h0;
      w_ctrl_d  = OP_ADD;
      w_valid_d = 1'b0;
    end else if (w_enter) begin
      unique case (r_stage)
        S_A: begin
          w_i1_d    = sw;
          w_stage_d = S_B;
        end
        S_B: begin
          w_i2_d    = sw;
          w_stage_d = S_OP;
        end
        S_OP: begin
          w_ctrl_d  = sw[1:0];
          w_valid_d = 1'b1;
          w_stage_d = S_SHOW;
        end
        S_SHOW: begin
          w_valid_d = 1'b0;
          w_stage_d = S_A;
        end
        default: w_stage_d = S_A;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage <= S_A;
      r_i1    <= 4'h0;
      r_i2    <= 4'h0;
      r_ctrl  <= OP_ADD;
      r_valid <= 1'b0;
    end else begin
      r_stage <= w_stage_d;
      r_i1    <= w_i1_d;
      r_i2    <= w_i2_d;
      r_ctrl  <= w_ctrl_d;
      r_valid <= w_valid_d;
    end
  end

  assign i1    = r_i1;
  assign i2    = r_i2;
  assign ctrl  = r_ctrl;
  assign valid = r_valid;
  assign stage = r_stage;

endmodule
